// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants and helpers for the FIFO read-side byte packer.
// Module widths are derived from their own parameters; these track the defaults.
package fifo_rd_pkg;

  localparam int DSIZE_DEF       = 8;
  localparam int LANES_DEF       = 4;
  localparam int BURST_WORDS_DEF = 30;

  localparam int LANE_IDX_W = $clog2(LANES_DEF);
  localparam int BCNT_W     = $clog2(BURST_WORDS_DEF);

  // LSB-contiguous mask with 'count' ones; callers cast down to their lane count.
  function automatic logic [31:0] keep_of(input logic [7:0] count);
    if (count >= 8'd32) begin
      return '1;
    end
    return (32'd1 << count) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-word output stream: valid/ready with per-lane keep and burst last.
interface fifo_rd_packer_if
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int LANES = LANES_DEF
);

  logic [DSIZE*LANES-1:0] m_data;
  logic [LANES-1:0]       m_keep;
  logic                   m_last;
  logic                   m_valid;
  logic                   m_ready;

  modport master (
    output m_data,
    output m_keep,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_keep,
    input  m_last,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_packer_lane_acc.sv
// Byte accumulator: LANES-1 lane registers, fill index and word-assembly mux.
// The assembled word already includes a byte being popped on the current edge.
module fifo_rd_lane_acc #(
  parameter int DSIZE = 8,
  parameter int LANES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [DSIZE-1:0]         rdata_i,
  output logic [$clog2(LANES)-1:0] idx_o,
  output logic [$clog2(LANES):0]   count_o,
  output logic                     complete_o,
  output logic [DSIZE*LANES-1:0]   word_o
);

  localparam int            IW      = $clog2(LANES);
  localparam logic [IW-1:0] TOP_IDX = IW'(LANES - 1);

  logic [DSIZE-1:0] lane_q [LANES-1];
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;

  assign complete_o = pop_i && (idx_q == TOP_IDX);
  assign idx_o      = idx_q;
  assign count_o    = {1'b0, idx_q} + {{IW{1'b0}}, pop_i};

  always_comb begin
    idx_d = idx_q;
    if (clear_i || complete_o) begin
      idx_d = '0;
    end else if (pop_i) begin
      idx_d = idx_q + IW'(1);
    end
  end

  // Lanes at or above idx are stale and masked to zero.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      if (IW'(i) < idx_q) begin
        word_o[i*DSIZE +: DSIZE] = lane_q[i];
      end else if ((IW'(i) == idx_q) && pop_i) begin
        word_o[i*DSIZE +: DSIZE] = rdata_i;
      end
    end
    if (complete_o) begin
      word_o[(LANES-1)*DSIZE +: DSIZE] = rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      idx_q <= '0;
      for (int i = 0; i < LANES - 1; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      for (int i = 0; i < LANES - 1; i++) begin
        if (pop_i && (idx_q == IW'(i))) begin
          lane_q[i] <= rdata_i;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the fifo1 read port, packs LANES bytes per word and streams them out
// with keep/last; flush emits a partial word and closes the burst.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE       = DSIZE_DEF,
  parameter int LANES       = LANES_DEF,
  parameter int BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  fifo_rd_packer_if.master m,
  output logic [15:0]      words_out
);

  localparam int IW = $clog2(LANES);
  localparam int BW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int WW = DSIZE * LANES;

  logic [IW-1:0]    idx;
  logic [IW:0]      count;
  logic             complete;
  logic [WW-1:0]    word;
  logic             acc_clear;

  logic [WW-1:0]    m_data_q,     m_data_d;
  logic [LANES-1:0] m_keep_q,     m_keep_d;
  logic             m_last_q,     m_last_d;
  logic             m_valid_q,    m_valid_d;
  logic [BW-1:0]    bcnt_q,       bcnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [15:0]      words_out_q,  words_out_d;

  logic             out_free;
  logic             pop;
  logic             hs;
  logic             flush_req;
  logic             emit_now;
  logic             emit_pend;
  logic             load;
  logic             force_last;
  logic [BW-1:0]    bcnt_eff;

  assign out_free = !m_valid_q || m.m_ready;
  assign pop      = rrst_n && !rempty && !flush_pend_q &&
                    ((idx != IW'(LANES - 1)) || out_free);
  assign rinc     = pop;

  fifo_rd_lane_acc #(
    .DSIZE (DSIZE),
    .LANES (LANES)
  ) u_acc (
    .clk_i      (rclk),
    .rst_n_i    (rrst_n),
    .pop_i      (pop),
    .clear_i    (acc_clear),
    .rdata_i    (rdata),
    .idx_o      (idx),
    .count_o    (count),
    .complete_o (complete),
    .word_o     (word)
  );

  always_comb begin
    hs         = m_valid_q && m.m_ready;
    flush_req  = flush && !flush_pend_q && (count != '0);
    emit_now   = flush_req && !complete && out_free;
    emit_pend  = flush_pend_q && out_free;
    load       = complete || emit_now || emit_pend;
    force_last = flush_req || emit_pend;
    acc_clear  = emit_now || emit_pend;

    // Burst position as seen after this edge's handshake, so a word loaded
    // while the previous one is accepted gets the right m_last.
    bcnt_eff = bcnt_q;
    if (hs) begin
      bcnt_eff = m_last_q ? '0 : bcnt_q + BW'(1);
    end

    bcnt_d       = bcnt_eff;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q && !hs;
    words_out_d  = hs ? words_out_q + 16'd1 : words_out_q;
    flush_pend_d = flush_pend_q;

    if (flush_req && !complete && !out_free) begin
      flush_pend_d = 1'b1;
    end else if (emit_pend) begin
      flush_pend_d = 1'b0;
    end

    if (load) begin
      m_data_d  = word;
      m_keep_d  = LANES'(keep_of(8'(count)));
      m_valid_d = 1'b1;
      m_last_d  = force_last || (bcnt_eff == BW'(BURST_WORDS - 1));
      if (force_last) begin
        bcnt_d = '0;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      bcnt_q       <= '0;
      flush_pend_q <= 1'b0;
      words_out_q  <= '0;
    end else begin
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
      bcnt_q       <= bcnt_d;
      flush_pend_q <= flush_pend_d;
      words_out_q  <= words_out_d;
    end
  end

  assign m.m_data   = m_data_q;
  assign m.m_keep   = m_keep_q;
  assign m.m_last   = m_last_q;
  assign m.m_valid  = m_valid_q;
  assign words_out  = words_out_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural FIFO source, accepted-word monitor,
// table of packing/flush vectors plus backpressure, pending-flush and reset cases.
module tb_fifo_rd_packer;

  localparam int M_NONE  = 0;
  localparam int M_AFTER = 1;
  localparam int M_WITH  = 2;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        rinc;
  logic        flush;
  logic [15:0] words_out;

  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.DSIZE(8), .LANES(4)) m_if ();

  fifo_rd_packer #(
    .DSIZE       (8),
    .LANES       (4),
    .BURST_WORDS (30)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .m         (m_if),
    .words_out (words_out)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          mode;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } vec_t;

  logic [7:0] fq[$];
  logic [7:0] wq[$];
  word_t      rx[$];
  int         rx_rd = 0;
  int         pops = 0;
  int         underflow = 0;
  int         checks = 0;
  int         failures = 0;

  vec_t        tbl [9];
  logic [7:0]  rb [120];
  int          base;
  int          nfirst;
  int          bcnt_m;
  int          exp_words;
  int          cyc;
  logic [31:0] exp_d;

  // FIFO model: bytes queued in wq become visible after the next edge.
  always @(posedge rclk) begin
    if (rinc) begin
      if (fq.size() == 0) begin
        underflow++;
      end else begin
        void'(fq.pop_front());
      end
      pops++;
    end
    while (wq.size() > 0) begin
      fq.push_back(wq.pop_front());
    end
    rempty <= (fq.size() == 0);
    rdata  <= (fq.size() != 0) ? fq[0] : 8'h00;
  end

  always @(posedge rclk) begin
    if (rrst_n && m_if.m_valid && m_if.m_ready) begin
      rx.push_back('{m_if.m_data, m_if.m_keep, m_if.m_last});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (pops < target && n < 200) begin
      @(negedge rclk);
      n++;
    end
    checks++;
    if (pops < target) begin
      failures++;
      $display("FAIL pop_wait: pops=%0d required %0d", pops, target);
    end
  endtask

  task automatic wait_rx(input int target, output int cycles);
    cycles = 0;
    while (rx.size() < target && cycles < 400) begin
      @(negedge rclk);
      cycles++;
    end
    checks++;
    if (rx.size() < target) begin
      failures++;
      $display("FAIL rx_wait: words=%0d required %0d", rx.size(), target);
    end
  endtask

  task automatic expect_word(input string name, input logic [31:0] d,
                             input logic [3:0] k, input logic l);
    int c;
    wait_rx(rx_rd + 1, c);
    if (rx.size() > rx_rd) begin
      chk({name, "_data"}, 64'(rx[rx_rd].d), 64'(d));
      chk({name, "_keep"}, 64'(rx[rx_rd].k), 64'(k));
      chk({name, "_last"}, 64'(rx[rx_rd].l), 64'(l));
      rx_rd++;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4, 32'h04030201, M_NONE,  32'h04030201, 4'hF, 1'b0};
    tbl[1] = '{4, 32'h08070605, M_NONE,  32'h08070605, 4'hF, 1'b0};
    tbl[2] = '{2, 32'h0000BBAA, M_AFTER, 32'h0000BBAA, 4'h3, 1'b1};
    tbl[3] = '{1, 32'h0000005A, M_AFTER, 32'h0000005A, 4'h1, 1'b1};
    tbl[4] = '{3, 32'h00332211, M_AFTER, 32'h00332211, 4'h7, 1'b1};
    tbl[5] = '{4, 32'hEFBEADDE, M_AFTER, 32'hEFBEADDE, 4'hF, 1'b0};
    tbl[6] = '{4, 32'hC4C3C2C1, M_WITH,  32'hC4C3C2C1, 4'hF, 1'b1};
    tbl[7] = '{1, 32'h00000077, M_WITH,  32'h00000077, 4'h1, 1'b1};
    tbl[8] = '{3, 32'h00A3A2A1, M_WITH,  32'h00A3A2A1, 4'h7, 1'b1};

    rrst_n = 1'b0;
    flush  = 1'b0;
    m_if.m_ready = 1'b1;
    repeat (2) @(negedge rclk);
    chk("rst_valid", 64'(m_if.m_valid), 64'(0));
    chk("rst_data",  64'(m_if.m_data),  64'(0));
    chk("rst_keep",  64'(m_if.m_keep),  64'(0));
    chk("rst_last",  64'(m_if.m_last),  64'(0));
    chk("rst_words", 64'(words_out),    64'(0));
    chk("rst_rinc",  64'(rinc),         64'(0));
    rrst_n = 1'b1;
    @(negedge rclk);

    bcnt_m = 0;
    exp_words = 0;
    for (int v = 0; v < 9; v++) begin
      base   = pops;
      nfirst = (tbl[v].mode == M_WITH) ? tbl[v].n - 1 : tbl[v].n;
      for (int i = 0; i < nfirst; i++) begin
        wq.push_back(tbl[v].bytes[8*i +: 8]);
      end
      wait_pops(base + nfirst);
      if (tbl[v].mode == M_AFTER) begin
        pulse_flush();
      end else if (tbl[v].mode == M_WITH) begin
        wq.push_back(tbl[v].bytes[8*(tbl[v].n-1) +: 8]);
        @(negedge rclk);
        pulse_flush();
      end
      expect_word($sformatf("vec%0d", v), tbl[v].d, tbl[v].k, tbl[v].l);
      bcnt_m = tbl[v].l ? 0 : bcnt_m + 1;
      exp_words++;
      chk($sformatf("vec%0d_bcnt", v),  64'(dut.bcnt_q), 64'(bcnt_m));
      chk($sformatf("vec%0d_words", v), 64'(words_out),  64'(exp_words));
    end

    // Full burst of 30 words at one byte per cycle.
    for (int i = 0; i < 120; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      wq.push_back(rb[i]);
    end
    wait_rx(rx_rd + 30, cyc);
    checks++;
    if (cyc > 124) begin
      failures++;
      $display("FAIL burst_rate: cycles=%0d required <= 124", cyc);
    end
    for (int w = 0; w < 30; w++) begin
      exp_d = {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
      if (rx.size() > rx_rd) begin
        chk($sformatf("burst%0d_data", w), 64'(rx[rx_rd].d), 64'(exp_d));
        chk($sformatf("burst%0d_last", w), 64'(rx[rx_rd].l), 64'(w == 29));
        rx_rd++;
      end
    end
    exp_words += 30;
    @(negedge rclk);
    chk("burst_bcnt",  64'(dut.bcnt_q), 64'(0));
    chk("burst_words", 64'(words_out),  64'(exp_words));

    // Backpressure: one word held, three more bytes accumulated, then stall.
    m_if.m_ready = 1'b0;
    base = pops;
    for (int i = 0; i < 10; i++) begin
      wq.push_back(8'(8'h30 + i));
    end
    repeat (15) @(negedge rclk);
    chk("bp_pops",  64'(pops - base),   64'(7));
    chk("bp_rinc",  64'(rinc),          64'(0));
    chk("bp_valid", 64'(m_if.m_valid),  64'(1));
    chk("bp_keep",  64'(m_if.m_keep),   64'(4'hF));
    for (int s = 0; s < 3; s++) begin
      @(negedge rclk);
      chk("bp_hold_data", 64'(m_if.m_data), 64'(32'h33323130));
      chk("bp_hold_last", 64'(m_if.m_last), 64'(0));
    end
    m_if.m_ready = 1'b1;
    expect_word("bp_w0", 32'h33323130, 4'hF, 1'b0);
    expect_word("bp_w1", 32'h37363534, 4'hF, 1'b0);
    wait_pops(base + 10);
    pulse_flush();
    expect_word("bp_tail", 32'h00003938, 4'h3, 1'b1);
    exp_words += 3;
    @(negedge rclk);
    chk("bp_bcnt", 64'(dut.bcnt_q), 64'(0));

    // Flush while the output is stalled with one byte accumulated.
    m_if.m_ready = 1'b0;
    base = pops;
    for (int i = 0; i < 5; i++) begin
      wq.push_back(8'(8'h40 + i));
    end
    wait_pops(base + 5);
    repeat (2) @(negedge rclk);
    pulse_flush();
    chk("fp_pend", 64'(dut.flush_pend_q), 64'(1));
    wq.push_back(8'h45);
    @(negedge rclk);
    chk("fp_rinc_blocked", 64'(rinc), 64'(0));
    pulse_flush();
    chk("fp_pend_hold", 64'(dut.flush_pend_q), 64'(1));
    chk("fp_pops",      64'(pops - base),      64'(5));
    m_if.m_ready = 1'b1;
    expect_word("fp_full", 32'h43424140, 4'hF, 1'b0);
    expect_word("fp_part", 32'h00000044, 4'h1, 1'b1);
    wait_pops(base + 6);
    chk("fp_pend_clr", 64'(dut.flush_pend_q), 64'(0));
    pulse_flush();
    expect_word("fp_next", 32'h00000045, 4'h1, 1'b1);
    exp_words += 3;
    @(negedge rclk);
    chk("fp_words", 64'(words_out), 64'(exp_words));

    // Reset with a held word and idx=3; partial data is discarded.
    m_if.m_ready = 1'b0;
    base = pops;
    for (int i = 0; i < 7; i++) begin
      wq.push_back(8'(8'h50 + i));
    end
    wait_pops(base + 7);
    for (int i = 0; i < 4; i++) begin
      wq.push_back(8'(8'h60 + i));
    end
    rrst_n = 1'b0;
    @(negedge rclk);
    chk("mrst_valid", 64'(m_if.m_valid), 64'(0));
    chk("mrst_data",  64'(m_if.m_data),  64'(0));
    chk("mrst_keep",  64'(m_if.m_keep),  64'(0));
    chk("mrst_last",  64'(m_if.m_last),  64'(0));
    chk("mrst_words", 64'(words_out),    64'(0));
    chk("mrst_rinc",  64'(rinc),         64'(0));
    chk("mrst_bcnt",  64'(dut.bcnt_q),   64'(0));
    rrst_n = 1'b1;
    m_if.m_ready = 1'b1;
    expect_word("post_rst", 32'h63626160, 4'hF, 1'b0);
    @(negedge rclk);
    chk("post_rst_words", 64'(words_out), 64'(1));
    chk("no_underflow",   64'(underflow), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
